booth_divider: RTL and testbench
================================

# booth_divider

Sequential signed divider, the inverse companion to the team's 8-bit Booth multiplier: a 16-bit two's-complement dividend divided by an 8-bit two's-complement divisor gives an 8-bit signed quotient and an 8-bit signed remainder. It uses the same start/done handshake as the multiplier, so either block can sit behind the same VIO/ILA debug top. Division is radix-2 restoring on magnitudes, one quotient bit per clock, followed by a sign fix-up.

## Interface
Parameters:
- DW, 16, dividend width
- VW, 8, divisor/quotient/remainder width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- dividend  in  16  signed numerator; latched when start is accepted
- divisor  in  8  signed denominator; latched when start is accepted
- quotient  out  8  signed quotient, truncated toward zero; reset 0
- remainder  out  8  signed remainder, sign of dividend; reset 0
- done  out  1  one-cycle pulse when results are valid; reset 0
- busy  out  1  high from accept until done; reset 0
- div_by_zero  out  1  divisor was 0 for the last operation; reset 0
- overflow  out  1  true quotient is outside -128..127; reset 0

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE: when start=1, latch the operands, set busy=1 and go to PREP. Flags and outputs keep their previous values until FIX or the error exit.
- PREP: compute the 16-bit magnitude of the dividend and the 8-bit magnitude of the divisor (|-128|=128, held in 9 bits), and the result signs. If divisor==0: quotient=0, remainder=0, div_by_zero=1, overflow=0, done=1, busy=0, go to IDLE. Otherwise clear the flags, load 16-bit partial remainder=0 and count=0, go to ITER.
- ITER: shift {rem,dq} left by 1; if rem>=|divisor|, subtract and set the quotient LSB to 1. Runs 16 iterations (count 0..15), giving a 16-bit unsigned quotient magnitude Qm and a remainder magnitude Rm<=127.
- FIX: quotient = low 8 bits of (neg_q ? -Qm : Qm); remainder = neg_n ? -Rm : Rm. overflow=1 if Qm>127 with a positive result, or Qm>128 with a negative result. Set done=1, busy=0, return to IDLE.
- start while busy is ignored; the operation in flight is not disturbed.
- start held high continuously: a new operation is accepted on the first IDLE cycle after done.
- Reset at any time, including mid-ITER: go to IDLE immediately and drive every output to its reset value; the partial operation is discarded.

## Timing
- Edge E0 samples start=1 in IDLE. PREP runs at E1. ITER runs at E2..E17. FIX runs at E18.
- Normal latency: done is high for the cycle after E18, i.e. 18 clocks after acceptance. Back-to-back throughput is one result per 19 clocks.
- Divide by zero: done is high for the cycle after E1 (latency 1).
- done is exactly one cycle wide. quotient, remainder and the flags are stable from done until the next operation's done.
- busy rises after E0 and falls in the same cycle that done rises.

## Structure
- Package booth_div_pkg holds: the state enum (IDLE, PREP, ITER, FIX), DW/VW constants, and the iteration count constant ITERS=16.
- One natural sub-module: div_abs, a combinational two's-complement magnitude-plus-sign unit. It is instantiated once for the dividend and once for the divisor, and reused for the FIX negation.
- Everything else is one always block for the FSM and datapath registers.

## Test plan
- 1000 / 10 -> after 18 clocks: done pulse, quotient=100, remainder=0, both flags 0, busy low the same cycle.
- -500 / 7 -> quotient=-71 (0xB9), remainder=-3 (0xFD); 500 / -7 -> quotient=-71, remainder=3; -16256 / -128 -> quotient=127, remainder=0.
- 32767 / 1 -> overflow=1, quotient=0xFF; -32768 / -1 -> overflow=1; -16384 / 128 is not representable, so use -16384 / -128 -> overflow=1 (true quotient 128).
- 1234 / 0 -> done after 1 clock, div_by_zero=1, quotient=0, remainder=0; the next 100 / 3 -> div_by_zero=0, quotient=33, remainder=1.
- Pulse start again at E5 with different operands -> ignored; the original result appears at E18.
- Assert rst at E9 mid-ITER -> all outputs 0 and busy 0 immediately, no done pulse; a fresh 100 / 3 then completes normally.

Source files
------------

// File: rtl/booth_div_pkg.sv
// Shared types and constants for the sequential signed divider.
//   DW    : dividend width
//   VW    : divisor / quotient / remainder width
//   ITERS : restoring iterations, one quotient-magnitude bit each
//   CW    : iteration counter width
package booth_div_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned VW    = 8;
    localparam int unsigned ITERS = 16;
    localparam int unsigned CW    = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/div_abs.sv
// Combinational conditional two's-complement negate.
// With neg_i tied to the operand sign it returns the magnitude; with neg_i
// driven by a result sign it applies the sign to a magnitude.
//   val_i  : W-bit operand
//   neg_i  : 1 = negate, 0 = pass through
//   res_o  : W-bit result (|-2^(W-1)| = 2^(W-1) fits as unsigned)
//   sign_o : MSB of val_i
module div_abs #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o,
    output logic         sign_o
);

    assign sign_o = val_i[W-1];
    assign res_o  = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: DW-bit dividend / VW-bit divisor -> VW-bit
// quotient (truncated toward zero) and VW-bit remainder (sign of dividend).
// Radix-2 restoring division on magnitudes, one bit per clock, then sign fix.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request, sampled only in IDLE
//   dividend    : signed numerator, latched on accept
//   divisor     : signed denominator, latched on accept
//   quotient    : signed quotient
//   remainder   : signed remainder
//   done        : one-cycle result-valid pulse
//   busy        : high from accept until done
//   div_by_zero : last operation had divisor 0
//   overflow    : true quotient outside the VW-bit signed range
module booth_divider
    import booth_div_pkg::*;
#(
    parameter int unsigned DW = booth_div_pkg::DW,
    parameter int unsigned VW = booth_div_pkg::VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          done,
    output logic          busy,
    output logic          div_by_zero,
    output logic          overflow
);

    // Largest quotient magnitudes representable for each result sign.
    localparam logic [DW-1:0] QMAX_POS = DW'((2 ** (VW - 1)) - 1);
    localparam logic [DW-1:0] QMAX_NEG = DW'(2 ** (VW - 1));

    state_t        state_q, state_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] dvs_mag_q, dvs_mag_d;
    logic          neg_q_q, neg_q_d;
    logic          neg_n_q, neg_n_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dq_q, dq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] abs_n_in, abs_n_res;
    logic          abs_n_neg, abs_n_sign;
    logic [VW-1:0] abs_d_in, abs_d_res;
    logic          abs_d_neg, abs_d_sign;
    logic [DW-1:0] rem_sh;
    logic [DW-1:0] dq_sh;

    // Negate units: operand magnitudes in PREP, sign application in FIX.
    always_comb begin
        abs_n_in  = dvd_q;
        abs_n_neg = dvd_q[DW-1];
        abs_d_in  = dvs_q;
        abs_d_neg = dvs_q[VW-1];
        if (state_q == FIX) begin
            abs_n_in  = dq_q;
            abs_n_neg = neg_q_q;
            abs_d_in  = rem_q[VW-1:0];
            abs_d_neg = neg_n_q;
        end
    end

    div_abs #(.W(DW)) u_abs_n (
        .val_i  (abs_n_in),
        .neg_i  (abs_n_neg),
        .res_o  (abs_n_res),
        .sign_o (abs_n_sign)
    );

    div_abs #(.W(VW)) u_abs_d (
        .val_i  (abs_d_in),
        .neg_i  (abs_d_neg),
        .res_o  (abs_d_res),
        .sign_o (abs_d_sign)
    );

    // {rem, dq} shifted left by one for the restoring step.
    assign rem_sh = {rem_q[DW-2:0], dq_q[DW-1]};
    assign dq_sh  = {dq_q[DW-2:0], 1'b0};

    // Next-state and datapath.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        dvs_mag_d   = dvs_mag_q;
        neg_q_d     = neg_q_q;
        neg_n_d     = neg_n_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end

            PREP: begin
                if (dvs_q == '0) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    dvs_mag_d = abs_d_res;
                    neg_q_d   = abs_n_sign ^ abs_d_sign;
                    neg_n_d   = abs_n_sign;
                    dq_d      = abs_n_res;
                    rem_d     = '0;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = ITER;
                end
            end

            ITER: begin
                if (rem_sh >= DW'(dvs_mag_q)) begin
                    rem_d = rem_sh - DW'(dvs_mag_q);
                    dq_d  = dq_sh | DW'(1);
                end else begin
                    rem_d = rem_sh;
                    dq_d  = dq_sh;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // Remainder magnitude is below |divisor| <= 128, so it
                // never exceeds 127 and its low VW bits carry it exactly.
                quotient_d  = abs_n_res[VW-1:0];
                remainder_d = abs_d_res;
                ovf_d       = neg_q_q ? (dq_q > QMAX_NEG) : (dq_q > QMAX_POS);
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvs_mag_q   <= '0;
            neg_q_q     <= 1'b0;
            neg_n_q     <= 1'b0;
            rem_q       <= '0;
            dq_q        <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            dvs_mag_q   <= dvs_mag_d;
            neg_q_q     <= neg_q_d;
            neg_n_q     <= neg_n_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider.
module tb_booth_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    booth_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation; returns clocks from acceptance edge to done.
    // pulse_at > 0 re-raises start with other operands so edge E<pulse_at> samples it.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input int pulse_at, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
            if (lat == pulse_at - 1) begin
                start    = 1'b1;
                dividend = 16'h1111;
                divisor  = 8'h05;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // Check a completed result, then that done drops and results hold.
    task automatic expect_res(input string tag, input int lat, input int exp_lat,
                              input logic [7:0] q, input logic [7:0] r,
                              input logic dbz, input logic ovf);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_quot"}, 32'(quotient), 32'(q));
        check({tag, "_rem"}, 32'(remainder), 32'(r));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(dbz));
        check({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_quot_hold"}, 32'(quotient), 32'(q));
    endtask

    initial begin
        int lat;
        int n;
        int dones;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_quot", 32'(quotient), 32'd0);
        check("reset_rem", 32'(remainder), 32'd0);
        check("reset_flags", 32'({done, busy, div_by_zero, overflow}), 32'd0);
        rst = 1'b0;

        run_op(16'h03E8, 8'h0A, 0, lat);   // 1000 / 10
        expect_res("d1000_10", lat, 18, 8'd100, 8'd0, 1'b0, 1'b0);

        run_op(16'hFE0C, 8'h07, 0, lat);   // -500 / 7
        expect_res("dm500_7", lat, 18, 8'hB9, 8'hFD, 1'b0, 1'b0);

        run_op(16'h01F4, 8'hF9, 0, lat);   // 500 / -7
        expect_res("d500_m7", lat, 18, 8'hB9, 8'h03, 1'b0, 1'b0);

        run_op(16'hC080, 8'h80, 0, lat);   // -16256 / -128
        expect_res("dm16256_m128", lat, 18, 8'h7F, 8'h00, 1'b0, 1'b0);

        run_op(16'h0080, 8'hFF, 0, lat);   // 128 / -1 = -128, representable
        expect_res("d128_m1", lat, 18, 8'h80, 8'h00, 1'b0, 1'b0);

        run_op(16'h7FFF, 8'h01, 0, lat);   // 32767 / 1
        expect_res("d32767_1", lat, 18, 8'hFF, 8'h00, 1'b0, 1'b1);

        run_op(16'h8000, 8'hFF, 0, lat);   // -32768 / -1 = 32768
        expect_res("dm32768_m1", lat, 18, 8'h00, 8'h00, 1'b0, 1'b1);

        run_op(16'hC000, 8'h80, 0, lat);   // -16384 / -128 = 128
        expect_res("dm16384_m128", lat, 18, 8'h80, 8'h00, 1'b0, 1'b1);

        run_op(16'h04D2, 8'h00, 0, lat);   // 1234 / 0
        expect_res("d1234_0", lat, 1, 8'h00, 8'h00, 1'b1, 1'b0);

        run_op(16'h0064, 8'h03, 0, lat);   // 100 / 3
        expect_res("d100_3", lat, 18, 8'd33, 8'd1, 1'b0, 1'b0);

        run_op(16'h03E8, 8'h0A, 5, lat);   // start pulsed mid-operation
        expect_res("ignore_start", lat, 18, 8'd100, 8'd0, 1'b0, 1'b0);

        // start held high: back-to-back results 19 clocks apart
        @(negedge clk);
        dividend = 16'h0064;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done && n < 60);
        check("held_first_latency", 32'(n), 32'd18);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done && n < 60);
        start = 1'b0;
        check("held_period", 32'(n), 32'd19);
        check("held_quot", 32'(quotient), 32'd33);

        // reset mid-ITER: everything clears at once and no done follows
        run_op(16'hFE0C, 8'h07, 0, lat);
        @(negedge clk);
        dividend = 16'h03E8;
        divisor  = 8'h0A;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_quot", 32'(quotient), 32'd0);
        check("midrst_rem", 32'(remainder), 32'd0);
        check("midrst_flags", 32'({done, busy, div_by_zero, overflow}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);

        run_op(16'h0064, 8'h03, 0, lat);
        expect_res("after_rst_100_3", lat, 18, 8'd33, 8'd1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
